spi_param_loader: RTL and testbench

Downstream consumer of the SPI input shift stage. Detects completion of each 32-bit SPI frame via the shift stage's `busy` flag and synchronises it into the system clock domain. It then latches and validates the frame and writes its 16-bit payload into one of four PID parameter registers (Kp, Ki, Kd, setpoint), which feed the PID datapath directly.

---
 rtl/spi_param_loader.sv | 155 +++++++++++++++
 tb/tb_spi_param_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spi_param_loader.sv
// spi_param_loader: takes completed 32-bit SPI frames from the shift stage,
// brings frame completion into the clk domain, validates each frame and
// writes its 16-bit payload into one of four PID parameter registers.
// Frame layout: [31:24] address, [23:8] data, [7:0] check byte.
// Optional feature macro: SPI_LOADER_CHECKSUM_EN enables the XOR check byte;
// when it is undefined the check byte is ignored and only the address is validated.
module spi_param_loader #(
  parameter int            DW     = 16,
  parameter logic [DW-1:0] KP_RST = '0,
  parameter logic [DW-1:0] KI_RST = '0,
  parameter logic [DW-1:0] KD_RST = '0,
  parameter logic [DW-1:0] SP_RST = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          spi_cs,
  input  logic          spi_busy,
  input  logic [31:0]   spi_frame,
  output logic [DW-1:0] kp,
  output logic [DW-1:0] ki,
  output logic [DW-1:0] kd,
  output logic [DW-1:0] setpoint,
  output logic [3:0]    param_upd,
  output logic          frame_err,
  output logic [7:0]    err_cnt
);

  typedef enum logic [2:0] {IDLE, LATCH, CHECK, WRITE, ERROR} state_e;

  state_e        state_q, state_d;
  logic          busy_meta_q, busy_s_q, busy_d1_q;
  logic          cs_meta_q, cs_s_q;
  logic          busy_fall;
  logic [31:0]   frame_q, frame_d;
  logic [DW-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [7:0]    addr;
  logic          addr_ok, chk_ok, ok;

  assign busy_fall = busy_d1_q & ~busy_s_q;
  assign addr      = frame_q[31:24];
  assign addr_ok   = (addr <= 8'h04);

`ifdef SPI_LOADER_CHECKSUM_EN
  assign chk_ok = (frame_q[7:0] == (frame_q[31:24] ^ frame_q[23:16] ^ frame_q[15:8]));
`else
  logic unused_chk;
  assign unused_chk = ^frame_q[7:0];
  assign chk_ok     = 1'b1;
`endif

  assign ok = addr_ok & chk_ok;

  // Two-flop synchronisers for busy and cs, plus a delayed busy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      busy_d1_q   <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
    end else begin
      busy_meta_q <= spi_busy;
      busy_s_q    <= busy_meta_q;
      busy_d1_q   <= busy_s_q;
      cs_meta_q   <= spi_cs;
      cs_s_q      <= cs_meta_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a busy fall outside IDLE is ignored, and one seen with CS high is an aborted frame
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (busy_fall && !cs_s_q) state_d = LATCH;
      LATCH:   state_d = CHECK;
      CHECK:   state_d = ok ? WRITE : ERROR;
      WRITE:   state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulse outputs are decoded from the one-cycle WRITE/ERROR states
  always_comb begin
    param_upd = 4'b0000;
    frame_err = 1'b0;
    if (state_q == WRITE) begin
      unique case (addr)
        8'h01:   param_upd = 4'b0001;
        8'h02:   param_upd = 4'b0010;
        8'h03:   param_upd = 4'b0100;
        8'h04:   param_upd = 4'b1000;
        default: param_upd = 4'b0000;
      endcase
    end
    if (state_q == ERROR) frame_err = 1'b1;
  end

  // Datapath next values: registers and error count update on leaving CHECK so they appear with the pulse
  always_comb begin
    frame_d   = frame_q;
    kp_d      = kp_q;
    ki_d      = ki_q;
    kd_d      = kd_q;
    sp_d      = sp_q;
    err_cnt_d = err_cnt_q;
    if (state_q == LATCH) frame_d = spi_frame;
    if (state_q == CHECK) begin
      if (ok) begin
        unique case (addr)
          8'h01:   kp_d = frame_q[23:8];
          8'h02:   ki_d = frame_q[23:8];
          8'h03:   kd_d = frame_q[23:8];
          8'h04:   sp_d = frame_q[23:8];
          default: ;
        endcase
      end else if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q   <= '0;
      kp_q      <= KP_RST;
      ki_q      <= KI_RST;
      kd_q      <= KD_RST;
      sp_q      <= SP_RST;
      err_cnt_q <= '0;
    end else begin
      frame_q   <= frame_d;
      kp_q      <= kp_d;
      ki_q      <= ki_d;
      kd_q      <= kd_d;
      sp_q      <= sp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign kp       = kp_q;
  assign ki       = ki_q;
  assign kd       = kd_q;
  assign setpoint = sp_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_spi_param_loader.sv
// tb_spi_param_loader: directed frames with hand-computed expectations pushed
// into a scoreboard queue; a monitor pops and compares on every output pulse.
module tb_spi_param_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        spi_cs;
  logic        spi_busy;
  logic [31:0] spi_frame;
  logic [15:0] kp, ki, kd, setpoint;
  logic [3:0]  param_upd;
  logic        frame_err;
  logic [7:0]  err_cnt;

  spi_param_loader #(
    .DW(16), .KP_RST(16'h0100), .KI_RST(16'h0000), .KD_RST(16'h0000), .SP_RST(16'h0000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_busy(spi_busy),
    .spi_frame(spi_frame), .kp(kp), .ki(ki), .kd(kd), .setpoint(setpoint),
    .param_upd(param_upd), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int cyc = 0;

  // Cycle counter used to check pulse latency
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  upd;
    logic        err;
    logic [15:0] kp, ki, kd, sp;
    logic [7:0]  ecnt;
    int          at;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int passes = 0;

  logic [15:0] mKp = 16'h0100, mKi = 16'h0000, mKd = 16'h0000, mSp = 16'h0000;
  logic [7:0]  mEcnt = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_kp"}, {16'h0, kp}, {16'h0, mKp});
    checkOutput({tag, "_ki"}, {16'h0, ki}, {16'h0, mKi});
    checkOutput({tag, "_kd"}, {16'h0, kd}, {16'h0, mKd});
    checkOutput({tag, "_sp"}, {16'h0, setpoint}, {16'h0, mSp});
    checkOutput({tag, "_err_cnt"}, {24'h0, err_cnt}, {24'h0, mEcnt});
    checkOutput({tag, "_pulses"}, {27'h0, param_upd, frame_err}, 32'h0);
  endtask

  // Monitor: every pulse must match the oldest expected response
  always @(negedge clk) begin
    if (reset_n && (param_upd != 4'b0 || frame_err)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {27'h0, param_upd, frame_err}, 32'h0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("param_upd", {28'h0, param_upd}, {28'h0, e.upd});
        checkOutput("frame_err", {31'h0, frame_err}, {31'h0, e.err});
        checkOutput("kp", {16'h0, kp}, {16'h0, e.kp});
        checkOutput("ki", {16'h0, ki}, {16'h0, e.ki});
        checkOutput("kd", {16'h0, kd}, {16'h0, e.kd});
        checkOutput("setpoint", {16'h0, setpoint}, {16'h0, e.sp});
        checkOutput("err_cnt", {24'h0, err_cnt}, {24'h0, e.ecnt});
        checkOutput("latency", cyc, e.at);
      end
    end
  end

  // Sends one complete frame with CS held low; upd/err are the hand-computed response
  task automatic applyStimulus(input logic [31:0] f, input logic [3:0] upd, input logic err);
    exp_t e;
    @(negedge clk);
    spi_cs   = 1'b0;
    spi_busy = 1'b1;
    repeat (3) @(negedge clk);
    spi_frame = f;
    @(negedge clk);
    spi_busy = 1'b0;
    if (upd[0]) mKp = f[23:8];
    if (upd[1]) mKi = f[23:8];
    if (upd[2]) mKd = f[23:8];
    if (upd[3]) mSp = f[23:8];
    if (err && mEcnt != 8'hFF) mEcnt = mEcnt + 8'd1;
    if (upd != 4'b0 || err) begin
      e.upd = upd; e.err = err;
      e.kp = mKp; e.ki = mKi; e.kd = mKd; e.sp = mSp;
      e.ecnt = mEcnt;
      e.at = cyc + 5;
      expQ.push_back(e);
    end
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checkOutput("timeout_waiting_pulse", expQ.size(), 0);
      expQ.delete();
    end
    repeat (10) @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    spi_cs    = 1'b1;
    spi_busy  = 1'b0;
    spi_frame = 32'h0;
    repeat (3) @(negedge clk);
    checkRegs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted while the FSM is in CHECK: frame lost, no pulse
    spi_cs   = 1'b0;
    spi_busy = 1'b1;
    repeat (3) @(negedge clk);
    spi_frame = 32'h01BEEF50;
    @(negedge clk);
    spi_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    checkRegs("mid_check_reset");

    applyStimulus(32'h02123424, 4'b0010, 1'b0);
    applyStimulus(32'h01A5A501, 4'b0001, 1'b0);
    applyStimulus(32'h040F0F04, 4'b1000, 1'b0);
`ifdef SPI_LOADER_CHECKSUM_EN
    applyStimulus(32'h03ABCD00, 4'b0000, 1'b1);
`else
    applyStimulus(32'h03ABCD00, 4'b0100, 1'b0);
`endif
    applyStimulus(32'h07555507, 4'b0000, 1'b1);

    // Frame aborted by CS going high before busy falls
    @(negedge clk);
    spi_cs   = 1'b0;
    spi_busy = 1'b1;
    repeat (3) @(negedge clk);
    spi_frame = 32'h01111101;
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    spi_busy = 1'b0;
    repeat (12) @(negedge clk);
    checkRegs("abort");

    applyStimulus(32'h00FFFF00, 4'b0000, 1'b0);
    checkRegs("noop");

    for (int n = 0; n < 259; n++) applyStimulus(32'h07555507, 4'b0000, 1'b1);
    checkOutput("err_cnt_saturated", {24'h0, err_cnt}, 32'h000000FF);
    checkRegs("final");
    checkOutput("queue_drained", expQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
